prio_arbiter_seq: RTL and testbench

- Registered, parametrised successor to the 16-to-4 priority encoder.
- Captures sticky request bits from N sources into a pending register.
- Selects one pending index per transfer, using either fixed priority (highest index wins) or round-robin.
- Presents the selected index on a one-entry valid/ready output stage; used wherever the design must serialise bursts of one-hot/multi-hot events into index codes.

---
 rtl/prio_arbiter_seq.sv | 82 ++++++++
 tb/tb_prio_arbiter_seq.sv | 301 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/prio_arbiter_seq.sv
// Registered priority / round-robin arbiter.
// Sticky request capture, one-entry valid/ready output stage.
module prio_arbiter_seq #(
    parameter int N = 16,
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [N-1:0] in,
    input  logic         mode,
    input  logic         out_ready,
    output logic [W-1:0] out,
    output logic         out_valid,
    output logic [N-1:0] pending,
    output logic         empty
);

    logic [W-1:0] last;
    logic [W-1:0] sel_fixed;
    logic [W-1:0] sel_rr;
    logic [W-1:0] sel;
    logic [N-1:0] sel_mask;
    logic         any;
    logic         load;

    assign any  = |pending;
    assign load = !out_valid || out_ready;

    // Highest set index wins; later loop iterations override earlier ones.
    always_comb begin
        sel_fixed = '0;
        for (int i = 0; i < N; i++) begin
            if (pending[i]) sel_fixed = W'(i);
        end
    end

    // Descending search from (last-1) mod N; offset 0 is applied last
    // so the nearest candidate below last has the final word.
    always_comb begin
        int           idx;
        logic [W-1:0] iw;
        sel_rr = '0;
        idx    = 0;
        iw     = '0;
        for (int k = N - 1; k >= 0; k--) begin
            idx = int'(last) - 1 - k;
            if (idx < 0) idx = idx + N;
            iw = W'(idx);
            if (pending[iw]) sel_rr = iw;
        end
    end

    assign sel = mode ? sel_rr : sel_fixed;

    always_comb begin
        sel_mask = '0;
        if (load && any) sel_mask = N'(1) << sel;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pending   <= '0;
            out       <= '0;
            out_valid <= 1'b0;
            last      <= '0;
        end else begin
            pending <= (pending & ~sel_mask) | in;
            if (load) begin
                if (any) begin
                    out       <= sel;
                    out_valid <= 1'b1;
                    last      <= sel;
                end else begin
                    out_valid <= 1'b0;
                end
            end
        end
    end

    assign empty = (pending == '0) && !out_valid;

endmodule

// File: tb/tb_prio_arbiter_seq.sv
// Directed bench for prio_arbiter_seq.
// Covers N=16 and a non-power-of-two N=5 instance.
module tb_prio_arbiter_seq;

    logic        clk;
    logic        rst;
    logic [15:0] in;
    logic        mode;
    logic        out_ready;
    logic [3:0]  out;
    logic        out_valid;
    logic [15:0] pending;
    logic        empty;

    logic [4:0]  in5;
    logic        mode5;
    logic        ready5;
    logic [2:0]  out5;
    logic        valid5;
    logic [4:0]  pending5;
    logic        empty5;

    int n_checks = 0;
    int n_fail   = 0;

    prio_arbiter_seq #(.N(16), .W(4)) dut (
        .clk(clk), .rst(rst), .in(in), .mode(mode),
        .out_ready(out_ready), .out(out), .out_valid(out_valid),
        .pending(pending), .empty(empty)
    );

    prio_arbiter_seq #(.N(5), .W(3)) dut5 (
        .clk(clk), .rst(rst), .in(in5), .mode(mode5),
        .out_ready(ready5), .out(out5), .out_valid(valid5),
        .pending(pending5), .empty(empty5)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        in = '0; mode = 1'b0; out_ready = 1'b0;
        in5 = '0; mode5 = 1'b0; ready5 = 1'b0;
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        step();
    endtask

    task automatic test_reset();
        do_reset();
        n_checks++;
        if (out_valid !== 1'b0 || out !== 4'd0 || pending !== 16'h0 || empty !== 1'b1) begin
            n_fail++;
            $display("FAIL reset: out=%0d valid=%b pending=%h empty=%b, want 0 0 0000 1",
                     out, out_valid, pending, empty);
        end
    endtask

    task automatic test_fixed();
        logic [3:0] exp [4];
        exp[0] = 4'd15; exp[1] = 4'd10; exp[2] = 4'd5; exp[3] = 4'd0;
        do_reset();
        out_ready = 1'b1;
        in = 16'h8421;
        step();
        in = '0;
        n_checks++;
        if (pending !== 16'h8421 || out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL fixed_latency: pending=%h valid=%b, want 8421 0", pending, out_valid);
        end
        for (int i = 0; i < 4; i++) begin
            step();
            n_checks++;
            if (out_valid !== 1'b1 || out !== exp[i]) begin
                n_fail++;
                $display("FAIL fixed_seq[%0d]: out=%0d valid=%b, want %0d 1", i, out, out_valid, exp[i]);
            end
        end
        step();
        n_checks++;
        if (out_valid !== 1'b0 || empty !== 1'b1 || out !== 4'd0) begin
            n_fail++;
            $display("FAIL fixed_drain: out=%0d valid=%b empty=%b, want 0 0 1", out, out_valid, empty);
        end
    endtask

    task automatic test_backpressure();
        logic [3:0] exp [3];
        exp[0] = 4'd10; exp[1] = 4'd5; exp[2] = 4'd0;
        do_reset();
        out_ready = 1'b0;
        in = 16'h8421;
        step();
        in = '0;
        for (int i = 0; i < 5; i++) step();
        n_checks++;
        if (out !== 4'd15 || out_valid !== 1'b1 || pending !== 16'h0421) begin
            n_fail++;
            $display("FAIL bp_hold: out=%0d valid=%b pending=%h, want 15 1 0421", out, out_valid, pending);
        end
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            n_checks++;
            if (out_valid !== 1'b1 || out !== exp[i]) begin
                n_fail++;
                $display("FAIL bp_release[%0d]: out=%0d valid=%b, want %0d 1", i, out, out_valid, exp[i]);
            end
        end
    endtask

    task automatic test_round_robin();
        logic [3:0] e;
        do_reset();
        mode = 1'b1;
        out_ready = 1'b1;
        in = 16'hFFFF;
        step();
        for (int i = 0; i < 18; i++) begin
            step();
            e = 4'(15 - (i % 16));
            n_checks++;
            if (out_valid !== 1'b1 || out !== e) begin
                n_fail++;
                $display("FAIL rr_seq[%0d]: out=%0d valid=%b, want %0d 1", i, out, out_valid, e);
            end
        end
        mode = 1'b0;
        step();
        for (int i = 0; i < 3; i++) begin
            step();
            n_checks++;
            if (out_valid !== 1'b1 || out !== 4'd15) begin
                n_fail++;
                $display("FAIL fixed_all[%0d]: out=%0d valid=%b, want 15 1", i, out, out_valid);
            end
        end
        in = '0;
    endtask

    task automatic test_collapse();
        do_reset();
        out_ready = 1'b0;
        in = 16'h0001;
        step();
        in = '0;
        step();
        for (int i = 0; i < 3; i++) begin
            in = 16'h0008;
            step();
            in = '0;
            step();
        end
        n_checks++;
        if (out !== 4'd0 || out_valid !== 1'b1 || pending !== 16'h0008) begin
            n_fail++;
            $display("FAIL collapse_hold: out=%0d valid=%b pending=%h, want 0 1 0008", out, out_valid, pending);
        end
        out_ready = 1'b1;
        step();
        n_checks++;
        if (out !== 4'd3 || out_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL collapse_grant: out=%0d valid=%b, want 3 1", out, out_valid);
        end
        for (int i = 0; i < 3; i++) begin
            step();
            n_checks++;
            if (out_valid !== 1'b0) begin
                n_fail++;
                $display("FAIL collapse_once[%0d]: out=%0d valid=%b, want valid 0", i, out, out_valid);
            end
        end
    endtask

    task automatic test_set_wins();
        do_reset();
        out_ready = 1'b1;
        in = 16'h0080;
        step();
        step();
        in = '0;
        n_checks++;
        if (out !== 4'd7 || out_valid !== 1'b1 || pending !== 16'h0080) begin
            n_fail++;
            $display("FAIL setwins_first: out=%0d valid=%b pending=%h, want 7 1 0080", out, out_valid, pending);
        end
        step();
        n_checks++;
        if (out !== 4'd7 || out_valid !== 1'b1 || pending !== 16'h0000) begin
            n_fail++;
            $display("FAIL setwins_second: out=%0d valid=%b pending=%h, want 7 1 0000", out, out_valid, pending);
        end
        step();
        n_checks++;
        if (out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL setwins_end: valid=%b, want 0", out_valid);
        end
    endtask

    task automatic test_async_reset();
        do_reset();
        mode = 1'b1;
        out_ready = 1'b0;
        in = 16'h0100;
        step();
        in = 16'h00F0;
        step();
        in = '0;
        n_checks++;
        if (out !== 4'd8 || out_valid !== 1'b1 || pending !== 16'h00F0) begin
            n_fail++;
            $display("FAIL areset_pre: out=%0d valid=%b pending=%h, want 8 1 00f0", out, out_valid, pending);
        end
        #2;
        rst = 1'b1;
        #1;
        n_checks++;
        if (out !== 4'd0 || out_valid !== 1'b0 || pending !== 16'h0 || empty !== 1'b1) begin
            n_fail++;
            $display("FAIL areset_now: out=%0d valid=%b pending=%h empty=%b, want 0 0 0000 1",
                     out, out_valid, pending, empty);
        end
        #1;
        rst = 1'b0;
        mode = 1'b1;
        out_ready = 1'b1;
        in = 16'h0001;
        step();
        in = '0;
        step();
        n_checks++;
        if (out !== 4'd0 || out_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL areset_first: out=%0d valid=%b, want 0 1", out, out_valid);
        end
        // A fresh pointer must start at 15, so 8 beats 0 here.
        rst = 1'b1;
        #1;
        rst = 1'b0;
        in = 16'h0101;
        step();
        in = '0;
        step();
        n_checks++;
        if (out !== 4'd8 || out_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL areset_ptr: out=%0d valid=%b, want 8 1", out, out_valid);
        end
    endtask

    task automatic test_n5();
        logic [2:0] e;
        do_reset();
        mode5 = 1'b1;
        ready5 = 1'b1;
        in5 = 5'b10001;
        step();
        for (int i = 0; i < 6; i++) begin
            step();
            e = (i % 2 == 0) ? 3'd4 : 3'd0;
            n_checks++;
            if (valid5 !== 1'b1 || out5 !== e) begin
                n_fail++;
                $display("FAIL n5_seq[%0d]: out=%0d valid=%b, want %0d 1", i, out5, valid5, e);
            end
        end
        in5 = 5'b00110;
        step();
        step();
        n_checks++;
        if (out5 !== 3'd2 || valid5 !== 1'b1) begin
            n_fail++;
            $display("FAIL n5_wrap: out=%0d valid=%b, want 2 1", out5, valid5);
        end
        in5 = '0;
    endtask

    initial begin
        test_reset();
        test_fixed();
        test_backpressure();
        test_round_robin();
        test_collapse();
        test_set_wins();
        test_async_reset();
        test_n5();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
